mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single-ported RAM between instruction fetch and data accesses issued under control-unit read/write enables.
- Sits between the datapath request/wait interface and the RAM model.
- Sequences one access at a time with a small FSM.
- Prioritises data, with an instruction-starvation guard, a RAM timeout, and halt gating.

Parameters:
- DATA_W, 32, width of addresses and data words.
- DSTREAK_MAX, 4, max consecutive data grants while an instruction fetch is pending.
- TIMEOUT, 64, max cycles in an access state without ram_ready before abort.

Ports:
- CLK  input  1  system clock, rising edge.
- nRST  input  1  asynchronous active-low reset.
- iREN  input  1  instruction fetch request; held until iwait low.
- iaddr  input  DATA_W  fetch address.
- iwait  output  1  fetch not complete.
- iload  output  DATA_W  fetched word, valid when iREN && !iwait.
- dREN  input  1  data read request.
- dWEN  input  1  data write request.
- daddr  input  DATA_W  data address.
- dstore  input  DATA_W  write data.
- dwait  output  1  data access not complete.
- dload  output  DATA_W  read word, valid when dREN && !dwait.
- halt  input  1  processor halted; blocks new fetch grants.
- ramREN  output  1  RAM read strobe.
- ramWEN  output  1  RAM write strobe.
- ramaddr  output  DATA_W  RAM address.
- ramstore  output  DATA_W  RAM write data.
- ramload  input  DATA_W  RAM read data.
- ram_ready  input  1  RAM completes current access this cycle.
- mem_err  output  1  sticky timeout flag.

Behaviour:
- Reset (async, nRST=0): state=IDLE, streak=0, tcnt=0, mem_err=0. ram* outputs 0; iwait=iREN, dwait=dREN|dWEN. Reset mid-access aborts it with no completion.
- States: IDLE, IACC, DACC.
- IDLE transitions, evaluated each cycle:
  - Data request (dREN|dWEN) and (!iREN || halt || streak<DSTREAK_MAX) -> DACC.
  - Else iREN && !halt -> IACC.
  - Else stay in IDLE.
- IDLE outputs: no RAM strobes; all waits follow their requests.
- IACC outputs: ramREN=1, ramaddr=iaddr.
- DACC outputs: ramaddr=daddr; ramWEN=dWEN, ramREN=dREN&!dWEN, ramstore=dstore. dREN&dWEN together is treated as a write.
- Completion: in IACC/DACC with ram_ready=1, the matching wait drops to 0 that cycle. iload/dload=ramload combinationally. Next state IDLE. Other wait stays 1.
- Latency: request seen in IDLE at cycle N; earliest completion cycle N+1. One mandatory IDLE cycle between accesses.
- Non-granted load output: 0.
- Requesters hold address/data stable while wait=1; the block does not latch them.
- Requester drops request mid-access: return to IDLE next cycle, no RAM strobes that cycle, no counter updates.
- streak:
  - +1 (saturating at DSTREAK_MAX) on data completion while iREN=1.
  - Cleared on instruction completion, or any cycle iREN=0.
- tcnt:
  - Cleared in IDLE and on completion; +1 each access cycle without ram_ready.
  - When tcnt==TIMEOUT-1 and no ram_ready: abort. Wait=0, load=0, mem_err set (held until reset), next IDLE.
- halt:
  - Never aborts an IACC already in progress.
  - While halt=1, no new IACC is entered; iwait stays 1; data accesses served normally.
- Simultaneous ram_ready and timeout in the same cycle: ram_ready wins, no error.

Test Plan:
- Single fetch: iREN=1, iaddr=0x40, ram_ready=1 from cycle 1, ramload=0x8C220004 -> cycle1 ramREN=1, ramaddr=0x40, iwait=0, iload=0x8C220004; cycle2 IDLE.
- Simultaneous: iREN, dREN, daddr=0x100, ram_ready=1 -> DACC first (dwait=0 cycle1), IACC next (iwait=0 cycle3).
- Starvation guard, DSTREAK_MAX=4: dREN and iREN held, ram_ready=1 -> exactly 4 data completions, then one fetch completion, then data resumes.
- Write: dWEN=1, dREN=1, daddr=0x200, dstore=0xDEADBEEF, ram_ready after 3 cycles -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait=0 only on ready cycle.
- Timeout, TIMEOUT=64: iREN=1, ram_ready=0 forever -> iwait=0, iload=0 at access cycle 64; mem_err=1 stays after iREN drops; nRST=0 clears it asynchronously.
- Halt/reset: halt=1 with iREN and dREN -> only data granted, iwait stays 1. Assert nRST=0 mid-DACC -> ram* outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data accesses.
// Data has priority, with a fetch-starvation guard, an access timeout and halt gating.
module mem_arbiter #(
    parameter int DATA_W      = 32,
    parameter int DSTREAK_MAX = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [DATA_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [DATA_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    input  logic              halt,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [DATA_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic              ram_ready,
    output logic              mem_err
);

    localparam int SW = $clog2(DSTREAK_MAX + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(DSTREAK_MAX);
    localparam logic [SW-1:0] STREAK_ONE = SW'(1);
    localparam logic [SW-1:0] STREAK_ZERO = SW'(0);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TCNT_ONE = TW'(1);
    localparam logic [TW-1:0] TCNT_ZERO = TW'(0);
    localparam logic [DATA_W-1:0] WORD_ZERO = {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IACC = 2'd1,
        DACC = 2'd2
    } state_t;

    state_t          state_r;
    logic [SW-1:0]   streak_r;
    logic [SW-1:0]   streak_nxt_s;
    logic [TW-1:0]   tcnt_r;
    logic            mem_err_r;
    logic            dreq_s;
    logic            tout_s;
    logic            go_d_s;
    logic            go_i_s;

    assign dreq_s  = dREN | dWEN;
    // ram_ready on the last allowed cycle still counts as a normal completion
    assign tout_s  = (tcnt_r == TCNT_LAST) && !ram_ready;
    assign go_d_s  = dreq_s && (!iREN || halt || (streak_r < STREAK_MAX));
    assign go_i_s  = iREN && !halt;
    assign mem_err = mem_err_r;

    // Requester-facing waits/loads and RAM strobes decoded from the current state
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = WORD_ZERO;
        ramstore = WORD_ZERO;
        iwait    = iREN;
        dwait    = dreq_s;
        iload    = WORD_ZERO;
        dload    = WORD_ZERO;
        case (state_r)
            IACC: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    iwait   = !(ram_ready || tout_s);
                    iload   = ram_ready ? ramload : WORD_ZERO;
                end else begin
                    iwait = 1'b0;
                end
            end
            DACC: begin
                if (dreq_s) begin
                    ramaddr  = daddr;
                    ramWEN   = dWEN;
                    ramREN   = dREN & !dWEN;
                    ramstore = dstore;
                    dwait    = !(ram_ready || tout_s);
                    dload    = (ram_ready && !dWEN) ? ramload : WORD_ZERO;
                end else begin
                    dwait = 1'b0;
                end
            end
            default: begin
                iwait = iREN;
                dwait = dreq_s;
            end
        endcase
    end

    // Consecutive-data-grant counter; only meaningful while a fetch is waiting
    always_comb begin
        streak_nxt_s = streak_r;
        if (!iREN) begin
            streak_nxt_s = STREAK_ZERO;
        end else if ((state_r == IACC) && ram_ready) begin
            streak_nxt_s = STREAK_ZERO;
        end else if ((state_r == DACC) && dreq_s && ram_ready) begin
            streak_nxt_s = (streak_r == STREAK_MAX) ? STREAK_MAX : streak_r + STREAK_ONE;
        end else begin
            streak_nxt_s = streak_r;
        end
    end

    // Access sequencer, timeout counter and sticky error flag
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r   <= IDLE;
            streak_r  <= STREAK_ZERO;
            tcnt_r    <= TCNT_ZERO;
            mem_err_r <= 1'b0;
        end else begin
            streak_r <= streak_nxt_s;
            case (state_r)
                IDLE: begin
                    tcnt_r <= TCNT_ZERO;
                    if (go_d_s) begin
                        state_r <= DACC;
                    end else if (go_i_s) begin
                        state_r <= IACC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                IACC, DACC: begin
                    if ((state_r == IACC) ? !iREN : !dreq_s) begin
                        state_r <= IDLE;
                    end else if (ram_ready) begin
                        state_r <= IDLE;
                        tcnt_r  <= TCNT_ZERO;
                    end else if (tout_s) begin
                        state_r   <= IDLE;
                        tcnt_r    <= TCNT_ZERO;
                        mem_err_r <= 1'b1;
                    end else begin
                        tcnt_r <= tcnt_r + TCNT_ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    tcnt_r  <= TCNT_ZERO;
                end
            endcase
        end
    end

endmodule
